// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection phase controller:
// the phase encoding, the one-hot lamp patterns and the default duration codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } phase_e;

  // Lamp patterns are {red, yellow, green}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [2:0] DUR_GREEN_DEF  = 3'd7;
  localparam logic [2:0] DUR_YELLOW_DEF = 3'd3;
  localparam logic [2:0] DUR_RED_DEF    = 3'd1;

  // Main-road lamp for a phase; anything not main-green/yellow shows red,
  // so an unexpected code can only ever fail towards red.
  function automatic logic [2:0] main_light_of(phase_e p);
    case (p)
      MAIN_GREEN:  return L_GRN;
      MAIN_YELLOW: return L_YEL;
      default:     return L_RED;
    endcase
  endfunction

  // Side-road lamp for a phase, red by default for the same reason.
  function automatic logic [2:0] side_light_of(phase_e p);
    case (p)
      SIDE_GREEN:  return L_GRN;
      SIDE_YELLOW: return L_YEL;
      default:     return L_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_tick_counter.sv
// Per-phase tick counter shared by every phase: ignores the tick on the entry
// cycle, counts accepted ticks up to the phase limit, optionally saturates at
// the limit instead of advancing, and clears itself whenever the phase advances.
module phase_tick_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [7:0] limit_i,
  input  logic       saturate_i,
  input  logic       force_adv_i,
  output logic       adv_o,
  output logic       at_limit_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       entry_q, entry_d;
  logic       accept;
  logic       last;

  // Decide whether this cycle's tick counts and whether the phase ends now
  always_comb begin
    accept     = tick_i && !entry_q;
    last       = (({1'b0, cnt_q} + 9'd1) == {1'b0, limit_i});
    adv_o      = force_adv_i || (accept && !saturate_i && last);
    at_limit_o = (cnt_q == limit_i);
    cnt_d      = cnt_q;
    if (adv_o) begin
      cnt_d = 8'd0;
    end else if (accept && (!saturate_i || (cnt_q < limit_i))) begin
      cnt_d = cnt_q + 8'd1;
    end
    entry_d    = adv_o;
  end

  // Count register and entry flag; entry is high after reset and after each advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      entry_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller. Sequences main/side lamps through
// green, yellow and all-red clearance, holding main green until side demand.
// Optional build macro PED_WALK_EN: a latched pedestrian request turns the
// ALL_RED_B clearance into a walk phase of WALK_TICKS with the walk lamp lit.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned RED_TICKS    = 1,
  parameter int unsigned WALK_TICKS   = 6,
  parameter logic [2:0]  DUR_GREEN    = DUR_GREEN_DEF,
  parameter logic [2:0]  DUR_YELLOW   = DUR_YELLOW_DEF,
  parameter logic [2:0]  DUR_RED      = DUR_RED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       side_req_i,
  input  logic       ped_req_i,
  output logic [2:0] dur_o,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       ped_walk_o,
  output logic [2:0] state_o
);

  localparam logic [7:0] G_LIM = 8'(GREEN_TICKS);
  localparam logic [7:0] Y_LIM = 8'(YELLOW_TICKS);
  localparam logic [7:0] R_LIM = 8'(RED_TICKS);
  localparam logic [7:0] W_LIM = 8'(WALK_TICKS);

  phase_e     state_q, state_d;
  logic       side_pend_q, side_pend_d;
  logic       walk_q, walk_d;
  logic [2:0] main_q, side_q, dur_q;
  logic [7:0] limit;
  logic       saturate;
  logic       force_adv;
  logic       adv;
  logic       at_limit;

  function automatic logic [2:0] dur_of(phase_e p);
    case (p)
      MAIN_GREEN, SIDE_GREEN:   return DUR_GREEN;
      MAIN_YELLOW, SIDE_YELLOW: return DUR_YELLOW;
      default:                  return DUR_RED;
    endcase
  endfunction

  phase_tick_counter u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick_i),
    .limit_i     (limit),
    .saturate_i  (saturate),
    .force_adv_i (force_adv),
    .adv_o       (adv),
    .at_limit_o  (at_limit)
  );

  // Per-phase tick limit; main green saturates and leaves only on side demand,
  // and illegal codes are pushed out without waiting for a tick
  always_comb begin
    limit     = R_LIM;
    saturate  = 1'b0;
    force_adv = 1'b0;
    case (state_q)
      MAIN_GREEN: begin
        limit     = G_LIM;
        saturate  = 1'b1;
        force_adv = at_limit && side_pend_q;
      end
      MAIN_YELLOW, SIDE_YELLOW: limit = Y_LIM;
      SIDE_GREEN:               limit = G_LIM;
      ALL_RED_A:                limit = R_LIM;
      ALL_RED_B:                limit = walk_q ? W_LIM : R_LIM;
      default:                  force_adv = 1'b1;
    endcase
  end

  // Fixed phase ring and side demand latch; clearing on entry to side green wins
  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        MAIN_GREEN:  state_d = MAIN_YELLOW;
        MAIN_YELLOW: state_d = ALL_RED_A;
        ALL_RED_A:   state_d = SIDE_GREEN;
        SIDE_GREEN:  state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B:   state_d = MAIN_GREEN;
        default:     state_d = ALL_RED_A;
      endcase
    end
    side_pend_d = (adv && (state_q == ALL_RED_A)) ? 1'b0 : (side_pend_q || side_req_i);
  end

`ifdef PED_WALK_EN
  logic ped_pend_q, ped_pend_d;

  // Walk is decided once, on entry to ALL_RED_B; the request latch clears on its exit
  always_comb begin
    walk_d     = adv ? ((state_d == ALL_RED_B) && ped_pend_q) : walk_q;
    ped_pend_d = (adv && (state_q == ALL_RED_B)) ? 1'b0 : (ped_pend_q || ped_req_i);
  end

  // Pedestrian request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end
`else
  logic unused_ped;
  assign unused_ped = ped_req_i;
  assign walk_d     = 1'b0;
`endif

  // Phase register with lamps and duration decoded from the next phase, so the
  // registered outputs always describe the phase held in state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAIN_GREEN;
      side_pend_q <= 1'b0;
      walk_q      <= 1'b0;
      main_q      <= L_GRN;
      side_q      <= L_RED;
      dur_q       <= DUR_GREEN;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      walk_q      <= walk_d;
      main_q      <= main_light_of(state_d);
      side_q      <= side_light_of(state_d);
      dur_q       <= dur_of(state_d);
    end
  end

  assign state_o      = state_q;
  assign main_light_o = main_q;
  assign side_light_o = side_q;
  assign dur_o        = dur_q;
  assign ped_walk_o   = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a phase-level reference model, a per-cycle
// compare process, directed scenarios with hand-computed phase lengths, then
// randomized ticks, requests and resets.
module tb_traffic_phase_ctrl;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       tick_i     = 1'b0;
  logic       side_req_i = 1'b0;
  logic       ped_req_i  = 1'b0;
  logic [2:0] dur_o, main_light_o, side_light_o, state_o;
  logic       ped_walk_o;

  int checks = 0;
  int errors = 0;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int R = 1;
  localparam int W = 6;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick_i),
    .side_req_i   (side_req_i),
    .ped_req_i    (ped_req_i),
    .dur_o        (dur_o),
    .main_light_o (main_light_o),
    .side_light_o (side_light_o),
    .ped_walk_o   (ped_walk_o),
    .state_o      (state_o)
  );

  // Phase tables indexed by phase number
  int         need_tab [6] = '{G, Y, R, G, Y, R};
  logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] dur_tab  [6] = '{3'd7, 3'd3, 3'd1, 3'd7, 3'd3, 3'd1};

  // Reference model state
  int m_phase = 0;
  int m_acc   = 0;
  bit m_first = 1'b1;
  bit m_side  = 1'b0;
  bit m_ped   = 1'b0;
  bit m_walk  = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int need;
    bit take, leave, old_ped;
    int nxt;
    if (!rst_n) begin
      m_phase = 0; m_acc = 0; m_first = 1'b1;
      m_side  = 1'b0; m_ped = 1'b0; m_walk = 1'b0;
    end else begin
      need    = (m_phase == 5 && m_walk) ? W : need_tab[m_phase];
      take    = tick_i && !m_first;
      leave   = 1'b0;
      old_ped = m_ped;
      nxt     = (m_phase + 1) % 6;
      if (m_phase == 0) begin
        if (m_acc == G && m_side) leave = 1'b1;
        else if (take && m_acc < G) m_acc++;
      end else if (take) begin
        if (m_acc + 1 == need) leave = 1'b1;
        else m_acc++;
      end
      if (leave && m_phase == 2) m_side = 1'b0;
      else m_side = m_side || side_req_i;
      if (PED) begin
        if (leave && m_phase == 5) m_ped = 1'b0;
        else m_ped = m_ped || ped_req_i;
      end
      if (leave) begin
        m_walk  = PED && (nxt == 5) && old_ped;
        m_phase = nxt;
        m_acc   = 0;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end
  end

  // Every cycle: outputs against the model, plus the never-both-non-red rule
  always @(negedge clk) begin
    chk("state", {5'd0, state_o}, 8'(m_phase));
    chk("main_light", {5'd0, main_light_o}, {5'd0, main_tab[m_phase]});
    chk("side_light", {5'd0, side_light_o}, {5'd0, side_tab[m_phase]});
    chk("dur", {5'd0, dur_o}, {5'd0, dur_tab[m_phase]});
    chk("ped_walk", {7'd0, ped_walk_o}, {7'd0, m_walk});
    chk("safety", {7'd0, (main_light_o != 3'b100) && (side_light_o != 3'b100)}, 8'd0);
  end

  task automatic wait_state(input logic [2:0] s, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_o != s && n < 100);
  endtask

  // Called at the negedge of a phase's first cycle; counts cycles spent in it
  task automatic measure(input string nm, input logic [2:0] s, input int len);
    int n;
    n = 0;
    while (state_o == s && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 8'(n), 8'(len));
  endtask

  task automatic pulse_side();
    @(posedge clk); #1 side_req_i = 1'b1;
    @(posedge clk); #1 side_req_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", {5'd0, state_o}, 8'd0);
    chk("rst_main", {5'd0, main_light_o}, 8'b001);
    chk("rst_side", {5'd0, side_light_o}, 8'b100);
    chk("rst_dur", {5'd0, dur_o}, 8'd7);
    chk("rst_walk", {7'd0, ped_walk_o}, 8'd0);

    // No demand: main green holds forever
    tick_i = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("hold_state", {5'd0, state_o}, 8'd0);
    chk("hold_main", {5'd0, main_light_o}, 8'b001);

    // Full cycle with tick held high
    pulse_side();
    wait_state(3'd1, n);
    chk("t3_exit_lat", 8'(n), 8'd2);
    measure("t3_main_yellow", 3'd1, 3);
    measure("t3_all_red_a", 3'd2, 2);
    measure("t3_side_green", 3'd3, 5);
    measure("t3_side_yellow", 3'd4, 3);
    measure("t3_all_red_b", 3'd5, 2);
    chk("t3_back_main", {5'd0, state_o}, 8'd0);

    // Tick on the yellow entry cycle must not count
    pulse_side();
    wait_state(3'd1, n);
    chk("t4_reach", {5'd0, state_o}, 8'd1);
    n = 1;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1 tick_i = (k % 4 == 0);
      @(negedge clk);
      if (state_o != 3'd1) break;
      n++;
    end
    chk("t4_yellow_len", 8'(n), 8'd9);
    tick_i = 1'b1;

    // Requests during side green re-arm demand for the next main green
    wait_state(3'd3, n);
    chk("t5_reach", {5'd0, state_o}, 8'd3);
    side_req_i = 1'b1;
    @(posedge clk); #1 side_req_i = 1'b0;
    @(posedge clk); #1 side_req_i = 1'b1;
    @(posedge clk); #1 side_req_i = 1'b0;
    wait_state(3'd0, n);
    measure("t5_main_green", 3'd0, 6);

    // Pedestrian request during side green
    wait_state(3'd3, n);
    ped_req_i = 1'b1;
    @(posedge clk); #1 ped_req_i = 1'b0;
    wait_state(3'd5, n);
    chk("t6_walk_on", {7'd0, ped_walk_o}, {7'd0, PED});
    measure("t6_all_red_b", 3'd5, PED ? 7 : 2);
    chk("t6_walk_off", {7'd0, ped_walk_o}, 8'd0);

    // Asynchronous reset in the middle of side green
    pulse_side();
    wait_state(3'd3, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_state", {5'd0, state_o}, 8'd0);
    chk("t1_main", {5'd0, main_light_o}, 8'b001);
    chk("t1_side", {5'd0, side_light_o}, 8'b100);
    chk("t1_dur", {5'd0, dur_o}, 8'd7);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      tick_i     = 1'($urandom_range(0, 1));
      side_req_i = ($urandom_range(0, 7) == 0);
      ped_req_i  = ($urandom_range(0, 7) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Two-road intersection phase controller. It sits at the other end of the timer interface. It drives a 3-bit duration code to the tick generator and consumes the generator's single-cycle tick pulse. It counts ticks per phase and sequences the main-road and side-road lights through green, yellow and all-red phases, with side-road demand extending main green.

Parameters:
GREEN_TICKS, 4, ticks per green phase (1..255)
YELLOW_TICKS, 2, ticks per yellow phase (1..255)
RED_TICKS, 1, ticks per all-red clearance phase (1..255)
WALK_TICKS, 6, ticks for the pedestrian all-red phase (1..255; used only with PED_WALK_EN)
DUR_GREEN, 3'd7, duration code driven in green phases
DUR_YELLOW, 3'd3, duration code driven in yellow phases
DUR_RED, 3'd1, duration code driven in all-red phases

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
tick_i  in  1  single-cycle pulse from tick generator
side_req_i  in  1  side-road vehicle sensor, level or pulse
ped_req_i  in  1  pedestrian button (ignored unless PED_WALK_EN)
dur_o  out  3  duration code to tick generator
main_light_o  out  3  {red,yellow,green}, one-hot
side_light_o  out  3  {red,yellow,green}, one-hot
ped_walk_o  out  1  walk lamp
state_o  out  3  current phase encoding, for debug

Behaviour:
- Clocking: one clock; rst_n asynchronous assert, synchronous deassert handled upstream. All outputs are registered and Moore-decoded from the state register.
- Reset values:
  - state = MAIN_GREEN (3'd0); main_light_o = 3'b001; side_light_o = 3'b100
  - dur_o = DUR_GREEN; ped_walk_o = 0; cnt = 0; entry = 1; side_pend = 0; ped_pend = 0
- Phases (state_o encoding):
  - MAIN_GREEN 0, MAIN_YELLOW 1, ALL_RED_A 2, SIDE_GREEN 3, SIDE_YELLOW 4, ALL_RED_B 5
  - Codes 6 and 7 are illegal and go to ALL_RED_A on the next clock.
- Lights per phase (main / side):
  - MAIN_GREEN: G / R
  - MAIN_YELLOW: Y / R
  - ALL_RED_A and ALL_RED_B: R / R
  - SIDE_GREEN: R / G
  - SIDE_YELLOW: R / Y
- dur_o per phase: green phases → DUR_GREEN; yellow phases → DUR_YELLOW; all-red phases → DUR_RED.
- Entry cycle:
  - entry = 1 for the first cycle in each phase, including the first cycle after reset.
  - tick_i is ignored while entry = 1, so a stale pulse from the generator cannot shorten a phase.
- Tick counter:
  - 8-bit cnt increments on tick_i when entry = 0.
  - A phase completes on the clock that accepts its Nth tick; cnt clears and entry sets on the same clock.
  - With tick_i held high, a phase lasts N+1 cycles.
- MAIN_GREEN extension:
  - After GREEN_TICKS ticks, cnt saturates at GREEN_TICKS.
  - Exit to MAIN_YELLOW on the first cycle with cnt == GREEN_TICKS and side_pend = 1; no tick is needed.
  - Otherwise the phase holds indefinitely.
- side_pend:
  - Set by side_req_i = 1 in any phase.
  - Cleared on the clock entering SIDE_GREEN.
  - If set and clear coincide, clear wins; a request arriving during SIDE_GREEN and later re-sets it.
- Fixed sequence: MAIN_YELLOW → ALL_RED_A → SIDE_GREEN → SIDE_YELLOW → ALL_RED_B → MAIN_GREEN, each after its tick count. SIDE_GREEN is never extended.
- Safety invariant: main and side are never simultaneously non-red.
- Reset mid-phase: immediate return to reset values, whatever the phase.

Optional Feature:
PED_WALK_EN.
- Defined:
  - ped_pend is set by ped_req_i.
  - If ped_pend = 1 on entry to ALL_RED_B, that phase lasts WALK_TICKS and ped_walk_o = 1 throughout it.
  - ped_pend clears on exit from ALL_RED_B.
- Undefined: ped_req_i is ignored, ped_walk_o is tied to 0, ALL_RED_B lasts RED_TICKS. The ports exist in both builds.

Decomposition:
- Package traffic_pkg holds:
  - phase enum (3-bit)
  - light constants: L_RED 3'b100, L_YEL 3'b010, L_GRN 3'b001
  - default duration codes
- One sub-module, phase_tick_counter: cnt, entry flag, limit compare, saturate, clear-on-advance. It is shared by all phases.

Test Plan:
All scenarios use default parameters unless stated.
1. Reset: rst_n low mid-SIDE_GREEN → same cycle main = 001, side = 100, state_o = 0, dur_o = 7.
2. No demand: tick_i = 1 constant, side_req_i = 0 for 50 cycles → stays MAIN_GREEN, cnt holds at 4.
3. Full cycle: side_req_i pulse at cycle 2, tick_i = 1 → MAIN_GREEN exits after cycle 4; then MAIN_YELLOW 3 cycles, ALL_RED_A 2, SIDE_GREEN 5, SIDE_YELLOW 3, ALL_RED_B 2, back to state 0. dur_o tracks the phase, and the never-both-non-red assertion passes.
4. Entry-tick rejection: tick_i pulses only on the entry cycle of MAIN_YELLOW, then every 4th cycle → the phase needs 2 accepted ticks; the entry pulse is not counted.
5. Request during SIDE_GREEN: side_req_i = 1 on the SIDE_GREEN entry cycle and again 2 cycles later → side_pend = 0 after entry, 1 after the second pulse, and MAIN_GREEN exits immediately after its 4 ticks.
6. PED_WALK_EN build: ped_req_i pulse during SIDE_GREEN → ALL_RED_B lasts 7 cycles with tick_i = 1, ped_walk_o = 1 only in that phase. Non-PED build: ped_walk_o stays 0.
